// File: rtl/tx_plcp_framer_pkg.sv
// Shared constants for the PLCP transmit framer: state codes, field lengths,
// preamble/seed defaults, encoder generators and the SIGNAL field builder.
package tx_plcp_framer_pkg;

  localparam int unsigned HDR_LEN  = 12;
  localparam int unsigned SIG_LEN  = 24;
  localparam int unsigned SVC_LEN  = 16;
  localparam int unsigned TAIL_LEN = 6;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SCR_W    = 7;
  localparam int unsigned ENC_K    = 7;
  localparam int unsigned RATE_W   = 4;
  localparam int unsigned LEN_W    = 12;

  localparam logic [HDR_LEN-1:0] HEADER_DEFAULT   = 12'hFFF;
  localparam logic [SCR_W-1:0]   SCR_SEED_DEFAULT = 7'b1011101;

  // Taps over the window {d(n), d(n-1), ..., d(n-6)}, MSB = newest bit
  localparam logic [ENC_K-1:0] GEN_A = 7'o133;
  localparam logic [ENC_K-1:0] GEN_B = 7'o171;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SIGNAL   = 3'd2;
  localparam logic [2:0] ST_SERVICE  = 3'd3;
  localparam logic [2:0] ST_DATA     = 3'd4;
  localparam logic [2:0] ST_TAIL     = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  // SIGNAL word, bit 0 sent first: RATE, reserved, LENGTH, even parity, tail
  function automatic logic [SIG_LEN-1:0] signal_word(input logic [RATE_W-1:0] rate,
                                                     input logic [LEN_W-1:0]  len);
    logic [16:0] low;
    low = {len, 1'b0, rate};
    return {6'b000000, ^low, low};
  endfunction

endpackage

// File: rtl/tx_plcp_framer_conv_encoder.sv
// K=7 rate-1/2 convolutional encoder; i_sel_b=0 emits A for the bit being
// taken, i_sel_b=1 emits B for the bit taken on the previous cycle.
module conv_encoder
  import tx_plcp_framer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_take,
  input  logic i_bit,
  input  logic i_sel_b,
  output logic o_coded_c
);

  logic [ENC_K-1:0] r_win;
  logic [ENC_K-1:0] w_win;

  always_comb begin
    w_win     = i_sel_b ? r_win : {i_bit, r_win[ENC_K-1:1]};
    o_coded_c = i_sel_b ? ^(w_win & GEN_B) : ^(w_win & GEN_A);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_win <= '0;
    end else if (i_take) begin
      r_win <= {i_bit, r_win[ENC_K-1:1]};
    end
  end

endmodule

// File: rtl/tx_plcp_framer.sv
// PLCP transmit framer: preamble, SIGNAL, SERVICE, DATA and TAIL serialised
// through one convolutional encoder. Define TX_SCRAMBLER_EN to scramble SERVICE/DATA.
module tx_plcp_framer
  import tx_plcp_framer_pkg::*;
#(
  parameter logic [HDR_LEN-1:0] HEADER   = HEADER_DEFAULT,
  parameter logic [SCR_W-1:0]   SCR_SEED = SCR_SEED_DEFAULT
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic [RATE_W-1:0] iRate,
  input  logic [LEN_W-1:0]  iLength,
  input  logic              iData,
  input  logic              iDataValid,
  output logic              oDataReq,
  output logic              oData,
  output logic              oValid,
  output logic [RATE_W-1:0] oRate,
  output logic              oBusy,
  output logic              oDone
);

  if (SCR_SEED == '0) begin : g_bad_seed
    $error("SCR_SEED must be nonzero");
  end

  logic [2:0]        r_state, w_state_nxt, w_after;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_phase, w_phase_nxt;
  logic [RATE_W-1:0] r_rate;
  logic [LEN_W-1:0]  r_len;
  logic              r_data, r_valid, r_data_req, r_busy, r_done;
  logic              w_data_nxt, w_valid_nxt;
  logic              w_take, w_raw, w_scramble, w_last, w_coded_st;
  logic              w_enc_bit, w_coded_c, w_accept, w_scr_fb;
  logic [3:0]        w_hdr_idx;
  logic [SIG_LEN-1:0] w_sig;
  logic [CNT_W-1:0]  w_data_bits;

  assign w_sig       = signal_word(r_rate, r_len);
  assign w_hdr_idx   = 4'(HDR_LEN - 1) - r_cnt[3:0];
  assign w_data_bits = {1'b0, r_len, 3'b000};
  assign w_accept    = r_data_req & iDataValid;
  assign w_enc_bit   = w_raw ^ (w_scramble & w_scr_fb);

`ifdef TX_SCRAMBLER_EN
  logic [SCR_W-1:0] r_scr;

  assign w_scr_fb = r_scr[6] ^ r_scr[3];

  // Reloaded on every SERVICE entry, advanced once per scrambled bit taken
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_scr <= '0;
    end else if (r_state == ST_SIGNAL && w_state_nxt == ST_SERVICE) begin
      r_scr <= SCR_SEED;
    end else if (w_take && w_scramble) begin
      r_scr <= {r_scr[SCR_W-2:0], w_scr_fb};
    end
  end
`else
  assign w_scr_fb = 1'b0;
`endif

  conv_encoder u_enc (
    .i_clk     (iClk),
    .i_rst_n   (iRst_n),
    .i_clr     (r_state == ST_IDLE),
    .i_take    (w_take),
    .i_bit     (w_enc_bit),
    .i_sel_b   (r_phase),
    .o_coded_c (w_coded_c)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_data_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_take      = 1'b0;
    w_raw       = 1'b0;
    w_scramble  = 1'b0;
    w_last      = 1'b0;
    w_coded_st  = 1'b0;
    w_after     = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (iStart) w_state_nxt = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        w_data_nxt  = HEADER[w_hdr_idx];
        w_valid_nxt = 1'b1;
        if (r_cnt == CNT_W'(HDR_LEN - 1)) begin
          w_state_nxt = ST_SIGNAL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_SIGNAL: begin
        w_coded_st = 1'b1;
        w_raw      = w_sig[r_cnt[4:0]];
        w_last     = (r_cnt == CNT_W'(SIG_LEN - 1));
        w_after    = ST_SERVICE;
      end
      ST_SERVICE: begin
        w_coded_st = 1'b1;
        w_scramble = 1'b1;
        w_last     = (r_cnt == CNT_W'(SVC_LEN - 1));
        w_after    = (r_len == '0) ? ST_TAIL : ST_DATA;
      end
      ST_DATA: begin
        w_coded_st = 1'b1;
        w_scramble = 1'b1;
        w_raw      = iData;
        w_last     = (r_cnt == w_data_bits - 16'd1);
        w_after    = ST_TAIL;
      end
      ST_TAIL: begin
        w_coded_st = 1'b1;
        w_last     = (r_cnt == CNT_W'(TAIL_LEN - 1));
        w_after    = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Coded states: phase 0 takes a bit and emits A, phase 1 emits B
    if (w_coded_st) begin
      if (r_phase) begin
        w_data_nxt  = w_coded_c;
        w_valid_nxt = 1'b1;
        w_phase_nxt = 1'b0;
        if (w_last) begin
          w_state_nxt = w_after;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end else if (r_state != ST_DATA || w_accept) begin
        w_take      = 1'b1;
        w_data_nxt  = w_coded_c;
        w_valid_nxt = 1'b1;
        w_phase_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_rate     <= '0;
      r_len      <= '0;
      r_data     <= 1'b0;
      r_valid    <= 1'b0;
      r_data_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_data_req <= (w_state_nxt == ST_DATA) && !w_phase_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (r_state == ST_DONE);
      if (r_state == ST_IDLE && iStart) begin
        r_rate <= iRate;
        r_len  <= iLength;
      end
    end
  end

  assign oDataReq = r_data_req;
  assign oData    = r_data;
  assign oValid   = r_valid;
  assign oRate    = r_rate;
  assign oBusy    = r_busy;
  assign oDone    = r_done;

endmodule

// File: tb/tb_tx_plcp_framer.sv
// Randomised frame bench for tx_plcp_framer against a bit-list model of the
// PLCP framing, scrambling and convolutional coding rules.
module tb_tx_plcp_framer;

  localparam logic [11:0] MDL_HDR  = 12'hFFF;
  localparam logic [6:0]  MDL_SEED = 7'b1011101;

  logic        iClk = 1'b0;
  logic        iRst_n, iStart, iData, iDataValid;
  logic [3:0]  iRate;
  logic [11:0] iLength;
  logic        oDataReq, oData, oValid, oBusy, oDone;
  logic [3:0]  oRate;

  int checks = 0;
  int errors = 0;

  tx_plcp_framer dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iRate(iRate),
    .iLength(iLength), .iData(iData), .iDataValid(iDataValid),
    .oDataReq(oDataReq), .oData(oData), .oValid(oValid), .oRate(oRate),
    .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClk = ~iClk;

  logic exp_q[$];
  logic cap_q[$];
  logic pay_q[$];
  logic enc_in[$];
  logic sig_parity;
  int   vcnt, run, max_run, req_cnt, done_cnt, acc_cnt;
  bit   prev_valid, mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic u_at(input int k);
    return (k < 0) ? 1'b0 : enc_in[k];
  endfunction

  // Expected coded stream built straight from the framing rules
  function automatic void build_model(input logic [3:0] rate, input logic [11:0] len);
    logic        par;
    logic        b;
    logic [11:0] hdr;
    int          n;
`ifdef TX_SCRAMBLER_EN
    logic        pn[$];
    logic [6:0]  seed;
`endif
    exp_q.delete();
    enc_in.delete();
    hdr = MDL_HDR;
    for (int i = 0; i < 12; i++) exp_q.push_back(hdr[11-i]);
    for (int i = 0; i < 4; i++) enc_in.push_back(rate[i]);
    enc_in.push_back(1'b0);
    for (int i = 0; i < 12; i++) enc_in.push_back(len[i]);
    par = 1'b0;
    for (int i = 0; i < 17; i++) par = par ^ enc_in[i];
    sig_parity = par;
    enc_in.push_back(par);
    repeat (6) enc_in.push_back(1'b0);
`ifdef TX_SCRAMBLER_EN
    seed = MDL_SEED;
    for (int i = 0; i < 7; i++) pn.push_back(seed[6-i]);
`endif
    n = 16 + 8 * int'(len);
    for (int i = 0; i < n; i++) begin
      b = (i < 16) ? 1'b0 : pay_q[i-16];
`ifdef TX_SCRAMBLER_EN
      pn.push_back(pn[i] ^ pn[i+3]);
      b = b ^ pn[i+7];
`endif
      enc_in.push_back(b);
    end
    repeat (6) enc_in.push_back(1'b0);
    for (int k = 0; k < enc_in.size(); k++) begin
      exp_q.push_back(u_at(k) ^ u_at(k-2) ^ u_at(k-3) ^ u_at(k-5) ^ u_at(k-6));
      exp_q.push_back(u_at(k) ^ u_at(k-1) ^ u_at(k-2) ^ u_at(k-3) ^ u_at(k-6));
    end
  endfunction

  // Compare every valid output bit against the model stream
  always @(negedge iClk) begin
    logic e;
    if (mon_en) begin
      if (oValid === 1'b1) begin
        vcnt++;
        run++;
        if (run > max_run) max_run = run;
        cap_q.push_back(oData);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got bit %0b, expected no more bits", oData);
        end else begin
          e = exp_q.pop_front();
          if (oData !== e) begin
            errors++;
            $display("FAIL stream_bit %0d: got %0b, expected %0b", vcnt, oData, e);
          end
        end
      end else begin
        run = 0;
      end
      if (oDataReq === 1'b1) req_cnt++;
      if (oDone === 1'b1) begin
        done_cnt++;
        check("done_after_last_valid", {oValid, prev_valid}, 32'b01);
      end
      prev_valid = (oValid === 1'b1);
    end
  end

  task automatic load_bytes(input logic [31:0] val, input int nbytes);
    pay_q.delete();
    for (int j = 0; j < nbytes; j++)
      for (int i = 0; i < 8; i++) pay_q.push_back(val[8*j+i]);
  endtask

  task automatic load_random(input int nbytes);
    pay_q.delete();
    repeat (8 * nbytes) pay_q.push_back(1'($urandom_range(1)));
  endtask

  task automatic run_frame(input logic [3:0] rate, input logic [11:0] len, input int stall_pct,
                           input int stall_after, input int rst_at, input bit pulse_start);
    int ptr, stall_left, budget, d0;
    bit v;
    ptr = 0; stall_left = 0; acc_cnt = 0;
    build_model(rate, len);
    @(negedge iClk);
    vcnt = 0; run = 0; max_run = 0; req_cnt = 0; d0 = done_cnt;
    cap_q.delete();
    iRate = rate; iLength = len; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0; iRate = 4'($urandom); iLength = 12'($urandom);
    budget = 400 + 80 * int'(len);
    while (done_cnt == d0 && budget > 0) begin
      if (rst_at >= 0 && vcnt >= rst_at) begin
        iRst_n = 1'b0; iDataValid = 1'b0;
        @(negedge iClk);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_outputs", {oData, oDataReq, oDone, oRate}, 32'd0);
        iRst_n = 1'b1;
        exp_q.delete();
        return;
      end
      iData = (ptr < pay_q.size()) ? pay_q[ptr] : 1'($urandom_range(1));
      v = 1'b1;
      if (stall_left > 0) begin
        v = 1'b0; stall_left--;
      end else if (int'($urandom_range(99)) < stall_pct) begin
        v = 1'b0;
      end
      iDataValid = v;
      if (oDataReq === 1'b1 && v) begin
        ptr++; acc_cnt++;
        if (acc_cnt == stall_after) stall_left = 5;
      end
      iStart = pulse_start && (oDataReq === 1'b1);
      if (iStart) iRate = 4'b0010;
      @(negedge iClk);
      budget--;
    end
    iStart = 1'b0; iDataValid = 1'b0;
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got no oDone, expected oDone within budget");
    end else begin
      check("accepted_bits", 32'(acc_cnt), 32'(8 * int'(len)));
      check("valid_cycles", 32'(vcnt), 32'(104 + 16 * int'(len)));
      check("model_drained", 32'(exp_q.size()), 32'd0);
      check("orate", 32'(oRate), 32'(rate));
      if (stall_pct == 0 && stall_after < 0) check("contiguous", 32'(max_run), 32'(vcnt));
      if (len == 0) check("no_data_req", 32'(req_cnt), 32'd0);
    end
  endtask

  initial begin
    logic [11:0] hv;
    logic [7:0]  sv;
    iRst_n = 1'b0; iStart = 1'b0; iData = 1'b0; iDataValid = 1'b0;
    iRate = '0; iLength = '0; mon_en = 1'b0;
    done_cnt = 0; prev_valid = 1'b0;
    repeat (3) @(negedge iClk);
    check("reset_outputs", {oData, oValid, oDataReq, oBusy, oDone, oRate}, 32'd0);
    iRst_n = 1'b1;
    mon_en = 1'b1;

    // Model pins for RATE=1101, LENGTH=1, payload A5
    load_bytes(32'hA5, 1);
    build_model(4'b1101, 12'd1);
    check("model_len", 32'(exp_q.size()), 32'd120);
    check("model_parity", 32'(sig_parity), 32'd0);
    for (int i = 0; i < 8; i++) sv[7-i] = exp_q[12+i];
    check("model_sig_first8", 32'(sv), 32'b11010001);

    run_frame(4'b1101, 12'd1, 0, -1, -1, 1'b0);
    for (int i = 0; i < 12; i++) hv[11-i] = cap_q[i];
    check("preamble_bits", 32'(hv), 32'hFFF);
    for (int i = 0; i < 8; i++) sv[7-i] = cap_q[12+i];
    check("signal_first8", 32'(sv), 32'b11010001);

    load_random(0);
    run_frame(4'b0110, 12'd0, 0, -1, -1, 1'b0);

    load_random(2);
    run_frame(4'b1011, 12'd2, 0, 3, -1, 1'b0);

    load_random(3);
    run_frame(4'b0101, 12'd3, 0, -1, 70, 1'b0);
    load_random(2);
    run_frame(4'b0011, 12'd2, 0, -1, -1, 1'b0);

    load_random(4);
    run_frame(4'b1101, 12'd4, 0, -1, -1, 1'b1);
    load_random(1);
    run_frame(4'b1111, 12'd1, 0, -1, -1, 1'b0);

    load_bytes(32'hDEADBEEF, 4);
    run_frame(4'b1001, 12'd4, 0, -1, -1, 1'b0);

    for (int f = 0; f < 6; f++) begin
      int nb;
      nb = int'($urandom_range(5));
      load_random(nb);
      run_frame(4'($urandom), 12'(nb), 30, -1, -1, 1'b0);
    end

    repeat (3) @(negedge iClk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_plcp_framer.md
TX_PLCP_FRAMER -- requirements
Module: tx_plcp_framer

Interface
REQ-001 SHALL have parameter HEADER, default 12'hFFF, meaning the PLCP preamble pattern sent MSB first.
REQ-002 SHALL have parameter SCR_SEED, default 7'b1011101, meaning the scrambler initial state (nonzero).
REQ-003 SHALL have port iClk, input, 1 bit: the single clock.
REQ-004 SHALL have port iRst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port iStart, input, 1 bit: frame start request, sampled only in IDLE.
REQ-006 SHALL have port iRate, input, 4 bits: RATE field, latched on start.
REQ-007 SHALL have port iLength, input, 12 bits: payload byte count, latched on start.
REQ-008 SHALL have port iData, input, 1 bit: serial payload bit.
REQ-009 SHALL have port iDataValid, input, 1 bit: iData is valid.
REQ-010 SHALL have port oDataReq, output, 1 bit: the block is ready to accept one payload bit.
REQ-011 SHALL have port oData, output, 1 bit: serial coded output bit.
REQ-012 SHALL have port oValid, output, 1 bit: oData is valid.
REQ-013 SHALL have port oRate, output, 4 bits: latched RATE for the downstream interleaver.
REQ-014 SHALL have port oBusy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port oDone, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-016 SHALL implement these states: IDLE, PREAMBLE, SIGNAL, SERVICE, DATA, TAIL, DONE.
REQ-017 IDLE with iStart=1 SHALL latch iRate/iLength and enter PREAMBLE; iStart in any other state SHALL be ignored.
REQ-018 PREAMBLE SHALL output HEADER bits MSB first, uncoded, one per cycle, 12 cycles, oValid=1.
REQ-019 SIGNAL SHALL encode 24 bits LSB first: RATE[0..3], reserved 0, LENGTH[0..11], even parity over the previous 17 bits, then 6 zero tail bits. The bits SHALL NOT be scrambled, SHALL produce 48 coded cycles, and the encoder SHALL start from all-zero.
REQ-020 SERVICE SHALL encode 16 zero bits through the scrambler, with the scrambler loaded to SCR_SEED on entry, producing 32 coded cycles.
REQ-021 DATA SHALL consume exactly 8*iLength payload bits; each bit is scrambled and then encoded.
REQ-022 Payload handshake: a bit SHALL be accepted on a cycle with oDataReq=1 and iDataValid=1.
REQ-023 oDataReq SHALL be asserted only in DATA, and only on the cycle in which the encoder can take a new bit.
REQ-024 With iDataValid held high, oValid SHALL stay continuously high through DATA, giving one coded bit per clock.
REQ-025 Underrun (iDataValid=0 while oDataReq=1) SHALL hold all state; oValid SHALL deassert after the pending coded bits drain, and no bit SHALL be dropped or duplicated.
REQ-026 iLength=0 SHALL skip DATA (SERVICE goes directly to TAIL).
REQ-027 TAIL SHALL encode 6 unscrambled zero bits, producing 12 coded cycles, which returns the encoder to all-zero.
REQ-028 DONE SHALL last 1 cycle with oDone=1 and oValid=0, then enter IDLE.
REQ-029 Encoder: K=7, generators 133/171 octal, rate 1/2. Output order SHALL be A then B per input bit.
REQ-030 The first coded bit SHALL appear on the cycle after its input bit is taken.
REQ-031 oData and oValid SHALL be registered outputs.
REQ-032 Scrambler: x^7+x^4+1.
REQ-033 Frame length without stalls SHALL be 12+48+32+16*iLength+12 valid cycles.
REQ-034 The bit counter SHALL be 16 bits wide; 8*4095 bits SHALL NOT overflow it.

Reset
REQ-035 iRst_n=0 at a clock edge SHALL force IDLE from any state, including mid-frame.
REQ-036 Reset SHALL clear the encoder and scrambler registers and all counters.
REQ-037 Reset SHALL set oData=0, oValid=0, oDataReq=0, oBusy=0, oDone=0 and oRate=0.
REQ-038 There SHALL be no partial-frame resumption after reset.

Configuration
REQ-039 Macro TX_SCRAMBLER_EN: when defined, SERVICE and DATA bits SHALL be scrambled per REQ-020/REQ-032.
REQ-040 When TX_SCRAMBLER_EN is undefined, the scrambler SHALL be removed and bits SHALL pass unmodified; all timing SHALL be identical.

Structure
REQ-041 A shared package SHALL hold: state encodings; HEADER default; field lengths (12, 24, 16, 6); generator polynomials; SCR_SEED default.
REQ-042 A sub-module conv_encoder (K=7 shift register plus A/B output mux, with clear input) SHALL be instantiated once. The scrambler SHALL be inline.

Verification
REQ-043 iRate=4'b1101, iLength=1, iData byte 8'hA5, iDataValid=1 -> 120 consecutive oValid cycles; first 12 bits all 1; SIGNAL parity bit 0; oDone 1 cycle after the last valid bit.
REQ-044 iLength=0 -> 104 valid cycles; oDataReq is never asserted.
REQ-045 iLength=2, iDataValid dropped for 5 cycles after the 3rd accepted bit -> exactly 16 bits accepted; 136 valid cycles total; the coded stream matches the no-stall reference.
REQ-046 iRst_n=0 during SERVICE cycle 10 -> the next cycle has oBusy=0, oValid=0; a fresh iStart then produces a correct full frame.
REQ-047 iStart pulsed during DATA -> ignored; after DONE, an iStart with iRate=4'b1111 gives oRate=4'b1111.
REQ-048 Loopback through the interleaver into the receive chain with iLength=4, payload 32'hDEADBEEF -> identical 32 bits recovered; RATE and LENGTH decoded as sent.
